// File: rtl/regfile_read_seq.sv
`default_nettype none
// ============================================================================
// Module   : regfile_read_seq
// Purpose  : Operand-fetch sequencer for a single-read-port register file.
//            It accepts a decode request carrying up to two source addresses,
//            reads them one per cycle through the shared read port, and
//            bypasses same-cycle write-port traffic. It keeps the held
//            operands coherent with later writes and returns both operands
//            together on a valid/ready handshake.
// Ports    : clk, rst          - clock, asynchronous active-high reset
//            req_*             - decode request (valid/ready, rs1, rs2, use_rs2)
//            rf_raddr/rf_rdata - register file read port (combinational read)
//            wb_*              - copy of the register file write port
//            rsp_*             - operand response (valid/ready, op1, op2)
//            busy              - sequencer is not idle
// Revision : 1.0 - initial release
// ============================================================================
module regfile_read_seq #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_rs1,
  input  logic [ADDR_WIDTH-1:0] req_rs2,
  input  logic                  req_use_rs2,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  input  logic                  wb_wen,
  input  logic [ADDR_WIDTH-1:0] wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_op1,
  output logic [DATA_WIDTH-1:0] rsp_op2,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_rs1;
  logic [ADDR_WIDTH-1:0] r_rs2;
  logic                  r_use_rs2;
  logic [DATA_WIDTH-1:0] r_op1;
  logic [DATA_WIDTH-1:0] r_op2;

  logic                  w_wb_live;
  logic                  w_hit1;
  logic                  w_hit2;
  logic [DATA_WIDTH-1:0] w_fwd1;
  logic [DATA_WIDTH-1:0] w_fwd2;

  // Writes to x0 never take effect, so they must neither bypass nor update.
  assign w_wb_live = wb_wen && (wb_waddr != '0);
  assign w_hit1    = w_wb_live && (wb_waddr == r_rs1);
  assign w_hit2    = w_wb_live && (wb_waddr == r_rs2);

  // A hit already implies a nonzero address, so x0 falls through to the
  // explicit zero even if the register file were to return garbage.
  assign w_fwd1 = (r_rs1 == '0) ? '0 : (w_hit1 ? wb_wdata : rf_rdata);
  assign w_fwd2 = (r_rs2 == '0) ? '0 : (w_hit2 ? wb_wdata : rf_rdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_use_rs2 <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_rs1     <= req_rs1;
            r_rs2     <= req_rs2;
            r_use_rs2 <= req_use_rs2;
            r_state   <= RD1;
          end
        end
        RD1: begin
          r_op1 <= w_fwd1;
          if (r_use_rs2) begin
            r_state <= RD2;
          end else begin
            r_op2   <= '0;
            r_state <= RESP;
          end
        end
        RD2: begin
          r_op2 <= w_fwd2;
          // op1 was captured last cycle; keep it in step with this write.
          if (w_hit1) begin
            r_op1 <= wb_wdata;
          end
          r_state <= RESP;
        end
        RESP: begin
          if (w_hit1) begin
            r_op1 <= wb_wdata;
          end
          if (r_use_rs2 && w_hit2) begin
            r_op2 <= wb_wdata;
          end
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read address depends only on registered state, never on live inputs.
  always_comb begin
    rf_raddr = '0;
    case (r_state)
      RD1:     rf_raddr = r_rs1;
      RD2:     rf_raddr = r_rs2;
      default: rf_raddr = '0;
    endcase
  end

  // The gate on rst keeps the request side closed for the whole reset pulse.
  assign req_ready = (r_state == IDLE) && !rst;
  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_op1   = r_op1;
  assign rsp_op2   = r_op2;

endmodule
`default_nettype wire

// File: tb/tb_regfile_read_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_read_seq
// Purpose  : Self-checking bench for regfile_read_seq. A behavioural register
//            file array supplies read data and absorbs writes. Expected
//            operands are simply the architectural register values at the
//            moment of observation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_read_seq;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic        req_use_rs2;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_op1;
  logic [31:0] rsp_op2;
  logic        busy;

  int checks;
  int failures;

  logic [31:0] regs [32];

  // Directed write injections, keyed by cycle index within a request.
  int          dw_cyc  [2];
  logic [4:0]  dw_addr [2];
  logic [31:0] dw_data [2];

  regfile_read_seq #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_use_rs2(req_use_rs2),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .wb_wen     (wb_wen),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_op1    (rsp_op1),
    .rsp_op2    (rsp_op2),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: x0 reads zero, writes to x0 are dropped.
  always @(posedge clk) begin
    if (wb_wen && wb_waddr != 5'd0) regs[wb_waddr] <= wb_wdata;
  end
  assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : regs[rf_raddr];

  function automatic logic [31:0] arch_val(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : regs[a];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_wr(input int c, input bit rnd, input logic [4:0] a1, input logic [4:0] a2);
    wb_wen   = 1'b0;
    wb_waddr = 5'd0;
    wb_wdata = 32'd0;
    if (rnd && $urandom_range(0, 1) == 1) begin
      wb_wen = 1'b1;
      case ($urandom_range(0, 3))
        0:       wb_waddr = a1;
        1:       wb_waddr = a2;
        2:       wb_waddr = 5'd0;
        default: wb_waddr = 5'($urandom_range(0, 31));
      endcase
      wb_wdata = $urandom;
    end
    for (int i = 0; i < 2; i++) begin
      if (dw_cyc[i] == c) begin
        wb_wen   = 1'b1;
        wb_waddr = dw_addr[i];
        wb_wdata = dw_data[i];
      end
    end
  endtask

  task automatic clear_dw();
    for (int i = 0; i < 2; i++) dw_cyc[i] = -1;
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 in the
  // cycle after the response handshake.
  task automatic run_req(input logic [4:0] a1, input logic [4:0] a2, input logic use2,
                         input int hold, input bit rnd_wr, input bit keep_req);
    int lat;
    int c;
    lat = use2 ? 3 : 2;
    c   = 0;
    req_valid   = 1'b1;
    req_rs1     = a1;
    req_rs2     = a2;
    req_use_rs2 = use2;
    rsp_ready   = 1'($urandom_range(0, 1));
    drive_wr(c, rnd_wr, a1, a2);
    @(negedge clk);
    check_eq("idle_req_ready", 32'(req_ready), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_raddr", 32'(rf_raddr), 32'd0);
    @(posedge clk); #1;
    for (int k = 1; k < lat; k++) begin
      c = k;
      // Scramble request inputs: the DUT must use the latched copy.
      req_valid   = keep_req;
      req_rs1     = 5'($urandom_range(0, 31));
      req_rs2     = 5'($urandom_range(0, 31));
      req_use_rs2 = 1'($urandom_range(0, 1));
      rsp_ready   = 1'($urandom_range(0, 1));
      drive_wr(c, rnd_wr, a1, a2);
      @(negedge clk);
      check_eq("rd_rsp_valid", 32'(rsp_valid), 32'd0);
      check_eq("rd_req_ready", 32'(req_ready), 32'd0);
      check_eq("rd_busy", 32'(busy), 32'd1);
      check_eq("rd_raddr", 32'(rf_raddr), (k == 1) ? 32'(a1) : 32'(a2));
      @(posedge clk); #1;
    end
    for (int h = 0; h <= hold; h++) begin
      c = lat + h;
      rsp_ready = (h == hold);
      drive_wr(c, rnd_wr, a1, a2);
      @(negedge clk);
      check_eq("resp_valid", 32'(rsp_valid), 32'd1);
      check_eq("resp_req_ready", 32'(req_ready), 32'd0);
      check_eq("resp_raddr", 32'(rf_raddr), 32'd0);
      check_eq("resp_op1", rsp_op1, arch_val(a1));
      check_eq("resp_op2", rsp_op2, use2 ? arch_val(a2) : 32'd0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    wb_wen    = 1'b0;
    wb_waddr  = 5'd0;
    wb_wdata  = 32'd0;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    wb_wen   = 1'b1;
    wb_waddr = a;
    wb_wdata = d;
    @(posedge clk); #1;
    wb_wen   = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_rs1     = 5'd0;
    req_rs2     = 5'd0;
    req_use_rs2 = 1'b0;
    rsp_ready   = 1'b0;
    wb_wen      = 1'b0;
    wb_waddr    = 5'd0;
    wb_wdata    = 32'd0;
    clear_dw();

    // Reset state
    @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_op1", rsp_op1, 32'd0);
    check_eq("rst_op2", rsp_op2, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    for (int i = 1; i < 32; i++) wr_reg(5'(i), $urandom);
    wr_reg(5'd5, 32'h11);
    wr_reg(5'd6, 32'h22);

    // Basic two-operand fetch
    run_req(5'd5, 5'd6, 1'b1, 0, 1'b0, 1'b0);
    // Zero source, rs2 skipped
    run_req(5'd0, 5'd7, 1'b0, 0, 1'b0, 1'b0);
    // Bypass during RD1
    dw_cyc[0] = 1; dw_addr[0] = 5'd5; dw_data[0] = 32'hAA;
    run_req(5'd5, 5'd6, 1'b1, 0, 1'b0, 1'b0);
    clear_dw();
    check_eq("bypass_reg5", regs[5], 32'hAA);
    // Coherence while held in RESP, then an ignored x0 write
    dw_cyc[0] = 3; dw_addr[0] = 5'd6; dw_data[0] = 32'h55;
    dw_cyc[1] = 4; dw_addr[1] = 5'd0; dw_data[1] = 32'hFF;
    run_req(5'd5, 5'd6, 1'b1, 3, 1'b0, 1'b0);
    clear_dw();
    // rs1 == rs2 with a write in RD2 and RESP
    dw_cyc[0] = 2; dw_addr[0] = 5'd9; dw_data[0] = 32'h1234;
    dw_cyc[1] = 3; dw_addr[1] = 5'd9; dw_data[1] = 32'h5678;
    run_req(5'd9, 5'd9, 1'b1, 1, 1'b0, 1'b0);
    clear_dw();
    // Backpressure with a pending request, then the next request back-to-back
    run_req(5'd1, 5'd2, 1'b1, 5, 1'b0, 1'b1);
    run_req(5'd3, 5'd4, 1'b0, 0, 1'b0, 1'b0);

    // Reset during RD2
    req_valid = 1'b1; req_rs1 = 5'd3; req_rs2 = 5'd4; req_use_rs2 = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_op1", rsp_op1, 32'd0);
    check_eq("midrst_op2", rsp_op2, 32'd0);
    check_eq("midrst_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_release_ready", 32'(req_ready), 32'd1);
    check_eq("midrst_release_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    run_req(5'd3, 5'd4, 1'b1, 0, 1'b0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      run_req(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              1'b1, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
